// File: rtl/vedic_64_div_if.sv
// Operand/result handshake bundle for the vedic_64_div restoring divider.
// Handshake rule (both sides): a transfer happens on a clk edge where valid and ready are both 1; the producer holds payload stable while valid waits for ready.
interface vedic_64_div_if #(
  parameter int WIDTH = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_zero;
  logic                 overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/vedic_64_div.sv
// Iterative 2*WIDTH / WIDTH unsigned restoring divider, one quotient bit per CALC edge.
// Define VEDIC_DIV_RADIX4_EN to retire two quotient bits per CALC edge instead.
module vedic_64_div #(
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  vedic_64_div_if.slave     bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
`ifdef VEDIC_DIV_RADIX4_EN
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH / 2);
`else
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
`endif

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  div_r;
  logic [WIDTH-1:0]  dlo_r;
  logic [WIDTH-1:0]  rem_r;
  logic [WIDTH-1:0]  quo_r;
  logic              dz_r;
  logic              ovf_r;
  logic              out_valid_r;
  logic              in_fire;
  logic              out_fire;
  logic              last_step;
  logic              div_is_zero;
  logic              hi_overflow;
  logic [WIDTH-1:0]  op_hi;
  logic [WIDTH:0]    s1;
`ifdef VEDIC_DIV_RADIX4_EN
  logic [WIDTH:0]    s2;
`endif

  // One restoring step: returns {quotient_bit, new_partial_remainder}.
  // With r < d the difference always fits in WIDTH bits, so modulo subtraction is exact.
  function automatic logic [WIDTH:0] rstep(input logic [WIDTH-1:0] r,
                                           input logic             b,
                                           input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   rp;
    logic [WIDTH-1:0] diff;
    rp   = {r, b};
    diff = rp[WIDTH-1:0] - d;
    if (rp >= {1'b0, d}) rstep = {1'b1, diff};
    else                 rstep = {1'b0, rp[WIDTH-1:0]};
  endfunction

  assign op_hi       = bus.dividend[2*WIDTH-1:WIDTH];
  assign div_is_zero = (bus.divisor == '0);
  assign hi_overflow = (op_hi >= bus.divisor);
  assign last_step   = (cnt == CW'(1));

  always_comb begin
    s1 = rstep(rem_r, dlo_r[WIDTH-1], div_r);
`ifdef VEDIC_DIV_RADIX4_EN
    s2 = rstep(s1[WIDTH-1:0], dlo_r[WIDTH-2], div_r);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_fire    = 1'b0;
    out_fire   = 1'b0;
    case (state)
      IDLE: begin
        in_fire = bus.in_valid;
        if (in_fire) state_next = (div_is_zero || hi_overflow) ? DONE : CALC;
      end
      CALC: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_fire = bus.out_ready;
        if (out_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      quo_r       <= '0;
      rem_r       <= '0;
      dz_r        <= 1'b0;
      ovf_r       <= 1'b0;
      cnt         <= '0;
      div_r       <= '0;
      dlo_r       <= '0;
    end else begin
      out_valid_r <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (in_fire) begin
            div_r <= bus.divisor;
            dlo_r <= bus.dividend[WIDTH-1:0];
            if (div_is_zero) begin
              dz_r  <= 1'b1;
              ovf_r <= 1'b0;
              quo_r <= '1;
              rem_r <= bus.dividend[WIDTH-1:0];
              cnt   <= '0;
            end else if (hi_overflow) begin
              dz_r  <= 1'b0;
              ovf_r <= 1'b1;
              quo_r <= '1;
              rem_r <= '0;
              cnt   <= '0;
            end else begin
              dz_r  <= 1'b0;
              ovf_r <= 1'b0;
              quo_r <= '0;
              rem_r <= op_hi;
              cnt   <= CNT_INIT;
            end
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
`ifdef VEDIC_DIV_RADIX4_EN
          quo_r <= {quo_r[WIDTH-3:0], s1[WIDTH], s2[WIDTH]};
          rem_r <= s2[WIDTH-1:0];
          dlo_r <= {dlo_r[WIDTH-3:0], 2'b00};
`else
          quo_r <= {quo_r[WIDTH-2:0], s1[WIDTH]};
          rem_r <= s1[WIDTH-1:0];
          dlo_r <= {dlo_r[WIDTH-2:0], 1'b0};
`endif
        end
        default: ;
      endcase
    end
  end

  // in_ready is forced low during reset so nothing is accepted while rst_n=0.
  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_r;
  assign bus.div_zero  = dz_r;
  assign bus.overflow  = ovf_r;
  assign dbg_state     = state;

endmodule
